// File: rtl/if_pkg.sv
// Shared types and constants for the fetch stage: FSM states, the IF/ID payload
// layout and helpers for building bubbles and range-checking word addresses.
package if_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } if_state_e;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] DEFAULT_NOP_WORD  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus1;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    function automatic ifid_t make_bubble(input logic [31:0] nop_word);
        ifid_t b;
        b.pc       = 32'h0;
        b.pc_plus1 = 32'h0;
        b.instr    = nop_word;
        b.valid    = 1'b0;
        return b;
    endfunction

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register. Bubble beats load; with neither asserted the
// register holds, which is how a stall freezes the decode stage.
module if_id_pipe_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_load,
    input  logic  i_bubble,
    input  ifid_t i_data,
    output ifid_t o_data
);

    localparam ifid_t BUBBLE = make_bubble(NOP_WORD);

    ifid_t r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= BUBBLE;
        end else if (i_bubble) begin
            r_data <= BUBBLE;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/if_pc_unit.sv
// Fetch-stage front end: program counter, redirect/stall/halt control and the
// out-of-range fault, feeding the IF/ID register toward decode.
module if_pc_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 1025,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
    parameter logic [31:0] NOP_WORD  = DEFAULT_NOP_WORD
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall_IF,
    input  logic        Branch_Taken_EX,
    input  logic [31:0] Branch_Target_EX,
    input  logic        Jump_ID,
    input  logic [31:0] Jump_Target_ID,
    output logic [31:0] PC_IF,
    input  logic [31:0] Instruction_IF,
    output logic [31:0] PC_ID,
    output logic [31:0] PC_Plus1_ID,
    output logic [31:0] Instruction_ID,
    output logic        Valid_ID,
    output logic        Halted,
    output logic        Fetch_Fault
);

    if_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_halted;
    logic        r_fault;

    if_state_e   w_state_next;
    logic [31:0] w_pc_next;
    logic        w_halted_next;
    logic        w_fault_next;
    logic        w_load;
    logic        w_bubble;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_target_ok;
    logic [31:0] w_pc_plus1;
    logic        w_seq_ok;
    ifid_t       w_ifid_in;
    ifid_t       w_ifid_q;

    // A taken branch in EX is older than a jump in ID, so it wins the target mux.
    assign w_redirect  = Branch_Taken_EX | Jump_ID;
    assign w_target    = Branch_Taken_EX ? Branch_Target_EX : Jump_Target_ID;
    assign w_target_ok = in_range(w_target, MEM_DEPTH);
    assign w_pc_plus1  = r_pc + 32'd1;
    assign w_seq_ok    = in_range(w_pc_plus1, MEM_DEPTH);

    assign w_ifid_in.pc       = r_pc;
    assign w_ifid_in.pc_plus1 = w_pc_plus1;
    assign w_ifid_in.instr    = Instruction_IF;
    assign w_ifid_in.valid    = 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_halted_next = r_halted;
        w_fault_next  = r_fault;
        w_load        = 1'b0;
        w_bubble      = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_bubble     = 1'b1;
                w_state_next = ST_RUN;
            end

            ST_RUN: begin
                if (w_redirect) begin
                    w_bubble = 1'b1;
                    if (w_target_ok) begin
                        w_pc_next = w_target;
                    end else begin
                        w_fault_next = 1'b1;
                        w_state_next = ST_FAULT;
                    end
                end else if (Stall_IF) begin
                    w_load = 1'b0;
                end else if (Instruction_IF == HALT_WORD) begin
                    w_load        = 1'b1;
                    w_halted_next = 1'b1;
                    w_state_next  = ST_HALTED;
                end else begin
                    // The last legal word is still delivered to decode before faulting.
                    w_load = 1'b1;
                    if (w_seq_ok) begin
                        w_pc_next = w_pc_plus1;
                    end else begin
                        w_fault_next = 1'b1;
                        w_state_next = ST_FAULT;
                    end
                end
            end

            ST_HALTED: begin
                if (w_redirect) begin
                    w_bubble      = 1'b1;
                    w_halted_next = 1'b0;
                    if (w_target_ok) begin
                        w_pc_next    = w_target;
                        w_state_next = ST_RUN;
                    end else begin
                        w_fault_next = 1'b1;
                        w_state_next = ST_FAULT;
                    end
                end else if (!Stall_IF) begin
                    w_bubble = 1'b1;
                end
            end

            ST_FAULT: begin
                w_bubble = 1'b1;
            end

            default: begin
                w_bubble     = 1'b1;
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_halted <= w_halted_next;
            r_fault  <= w_fault_next;
        end
    end

    if_id_pipe_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_data   (w_ifid_in),
        .o_data   (w_ifid_q)
    );

    assign PC_IF          = r_pc;
    assign PC_ID          = w_ifid_q.pc;
    assign PC_Plus1_ID    = w_ifid_q.pc_plus1;
    assign Instruction_ID = w_ifid_q.instr;
    assign Valid_ID       = w_ifid_q.valid;
    assign Halted         = r_halted;
    assign Fetch_Fault    = r_fault;

endmodule

// File: tb/tb_if_pc_unit.sv
// Scoreboard bench for if_pc_unit: directed vectors queue their expected
// post-edge outputs and an independent monitor pops and compares them.
module tb_if_pc_unit;

    logic        Clk;
    logic        Reset_n;
    logic        Stall_IF;
    logic        Branch_Taken_EX;
    logic [31:0] Branch_Target_EX;
    logic        Jump_ID;
    logic [31:0] Jump_Target_ID;
    logic [31:0] PC_IF;
    logic [31:0] Instruction_IF;
    logic [31:0] PC_ID;
    logic [31:0] PC_Plus1_ID;
    logic [31:0] Instruction_ID;
    logic        Valid_ID;
    logic        Halted;
    logic        Fetch_Fault;

    typedef struct packed {
        logic [31:0] pcIf;
        logic [31:0] pcId;
        logic [31:0] pcPlus1Id;
        logic [31:0] instrId;
        logic        validId;
        logic        halted;
        logic        fault;
    } exp_t;

    logic [31:0] mem [0:1024];
    exp_t        expQ[$];
    string       nameQ[$];
    int          testsRun;
    int          testsFailed;
    exp_t        monExp;
    string       monName;

    if_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_DEPTH (1025),
        .HALT_WORD (32'hFFFF_FFFF),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Stall_IF         (Stall_IF),
        .Branch_Taken_EX  (Branch_Taken_EX),
        .Branch_Target_EX (Branch_Target_EX),
        .Jump_ID          (Jump_ID),
        .Jump_Target_ID   (Jump_Target_ID),
        .PC_IF            (PC_IF),
        .Instruction_IF   (Instruction_IF),
        .PC_ID            (PC_ID),
        .PC_Plus1_ID      (PC_Plus1_ID),
        .Instruction_ID   (Instruction_ID),
        .Valid_ID         (Valid_ID),
        .Halted           (Halted),
        .Fetch_Fault      (Fetch_Fault)
    );

    assign Instruction_IF = (PC_IF < 32'd1025) ? mem[PC_IF[10:0]] : 32'h0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t expRun(input logic [31:0] pcIf, input logic [31:0] pcId,
                                    input logic [31:0] instr);
        exp_t e;
        e.pcIf      = pcIf;
        e.pcId      = pcId;
        e.pcPlus1Id = pcId + 32'd1;
        e.instrId   = instr;
        e.validId   = 1'b1;
        e.halted    = 1'b0;
        e.fault     = 1'b0;
        return e;
    endfunction

    function automatic exp_t expBub(input logic [31:0] pcIf, input logic halted,
                                    input logic fault);
        exp_t e;
        e.pcIf      = pcIf;
        e.pcId      = 32'h0;
        e.pcPlus1Id = 32'h0;
        e.instrId   = 32'h0;
        e.validId   = 1'b0;
        e.halted    = halted;
        e.fault     = fault;
        return e;
    endfunction

    function automatic exp_t expFull(input logic [31:0] pcIf, input logic [31:0] pcId,
                                     input logic [31:0] instr, input logic halted,
                                     input logic fault);
        exp_t e;
        e        = expRun(pcIf, pcId, instr);
        e.halted = halted;
        e.fault  = fault;
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        testsRun++;
        if (PC_IF !== e.pcIf || PC_ID !== e.pcId || PC_Plus1_ID !== e.pcPlus1Id ||
            Instruction_ID !== e.instrId || Valid_ID !== e.validId ||
            Halted !== e.halted || Fetch_Fault !== e.fault) begin
            testsFailed++;
            $display("[TB] FAIL %s: got pc_if=%h pc_id=%h pc1=%h instr=%h valid=%b halted=%b fault=%b, want pc_if=%h pc_id=%h pc1=%h instr=%h valid=%b halted=%b fault=%b",
                     name, PC_IF, PC_ID, PC_Plus1_ID, Instruction_ID, Valid_ID, Halted,
                     Fetch_Fault, e.pcIf, e.pcId, e.pcPlus1Id, e.instrId, e.validId,
                     e.halted, e.fault);
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and queues the state expected after the next rising edge.
    task automatic applyStimulus(input string name, input logic stall, input logic br,
                                 input logic [31:0] brTarget, input logic jmp,
                                 input logic [31:0] jmpTarget, input exp_t e);
        Stall_IF         = stall;
        Branch_Taken_EX  = br;
        Branch_Target_EX = brTarget;
        Jump_ID          = jmp;
        Jump_Target_ID   = jmpTarget;
        expQ.push_back(e);
        nameQ.push_back(name);
        @(negedge Clk);
    endtask

    task automatic stepPlain(input string name, input exp_t e);
        applyStimulus(name, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, e);
    endtask

    task automatic clearInputs();
        Stall_IF         = 1'b0;
        Branch_Taken_EX  = 1'b0;
        Branch_Target_EX = 32'h0;
        Jump_ID          = 1'b0;
        Jump_Target_ID   = 32'h0;
    endtask

    task automatic pulseReset(input string name);
        clearInputs();
        Reset_n = 1'b0;
        #1;
        checkOutput(name, expBub(32'h0, 1'b0, 1'b0));
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Monitor: each rising edge retires the oldest queued expectation.
    always @(posedge Clk) begin
        #1;
        if (expQ.size() > 0) begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            checkOutput(monName, monExp);
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        for (int i = 0; i < 1025; i++) mem[i] = 32'h1000_0000 | i;
        mem[0]    = 32'h11;
        mem[1]    = 32'h22;
        mem[2]    = 32'h33;
        mem[3]    = 32'h44;
        mem[4]    = 32'h55;
        mem[5]    = 32'hFFFF_FFFF;
        mem[16]   = 32'hA0;
        mem[17]   = 32'hA1;
        mem[64]   = 32'h77;
        mem[1023] = 32'hCAFE;
        mem[1024] = 32'hBEEF;

        clearInputs();
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        @(negedge Clk);
        checkOutput("reset_state", expBub(32'h0, 1'b0, 1'b0));
        Reset_n = 1'b1;

        stepPlain("boot",         expBub(32'h0, 1'b0, 1'b0));
        stepPlain("fetch0",       expRun(32'h1, 32'h0, 32'h11));
        stepPlain("fetch1",       expRun(32'h2, 32'h1, 32'h22));
        applyStimulus("stall_a", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, expRun(32'h2, 32'h1, 32'h22));
        applyStimulus("stall_b", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, expRun(32'h2, 32'h1, 32'h22));
        stepPlain("resume",       expRun(32'h3, 32'h2, 32'h33));
        stepPlain("fetch3",       expRun(32'h4, 32'h3, 32'h44));
        applyStimulus("branch_prio", 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, expBub(32'h40, 1'b0, 1'b0));
        stepPlain("after_branch", expRun(32'h41, 32'h40, 32'h77));
        applyStimulus("jump_to4", 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, expBub(32'h4, 1'b0, 1'b0));
        stepPlain("fetch4",       expRun(32'h5, 32'h4, 32'h55));
        stepPlain("halt_capture", expFull(32'h5, 32'h5, 32'hFFFF_FFFF, 1'b1, 1'b0));
        stepPlain("halted_bubble", expBub(32'h5, 1'b1, 1'b0));
        applyStimulus("halted_stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, expBub(32'h5, 1'b1, 1'b0));
        applyStimulus("halt_jump", 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, expBub(32'h10, 1'b0, 1'b0));
        stepPlain("fetch10",      expRun(32'h11, 32'h10, 32'hA0));
        stepPlain("fetch11",      expRun(32'h12, 32'h11, 32'hA1));

        #2;
        pulseReset("async_reset");
        stepPlain("boot2",        expBub(32'h0, 1'b0, 1'b0));
        stepPlain("fetch0b",      expRun(32'h1, 32'h0, 32'h11));
        applyStimulus("jump_oor", 1'b0, 1'b0, 32'h0, 1'b1, 32'd1025, expBub(32'h1, 1'b0, 1'b1));
        applyStimulus("fault_branch", 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, expBub(32'h1, 1'b0, 1'b1));
        applyStimulus("fault_jump", 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, expBub(32'h1, 1'b0, 1'b1));
        stepPlain("fault_hold",   expBub(32'h1, 1'b0, 1'b1));

        pulseReset("fault_reset");
        stepPlain("boot3",        expBub(32'h0, 1'b0, 1'b0));
        applyStimulus("jump_1023", 1'b0, 1'b0, 32'h0, 1'b1, 32'd1023, expBub(32'd1023, 1'b0, 1'b0));
        stepPlain("fetch1023",    expRun(32'd1024, 32'd1023, 32'hCAFE));
        stepPlain("fetch_last",   expFull(32'd1024, 32'd1024, 32'hBEEF, 1'b0, 1'b1));
        stepPlain("after_last",   expBub(32'd1024, 1'b0, 1'b1));

        pulseReset("reset3");
        applyStimulus("boot_ignores", 1'b0, 1'b0, 32'h0, 1'b1, 32'h30, expBub(32'h0, 1'b0, 1'b0));
        applyStimulus("jump_to5", 1'b0, 1'b0, 32'h0, 1'b1, 32'h5, expBub(32'h5, 1'b0, 1'b0));
        stepPlain("halt_capture2", expFull(32'h5, 32'h5, 32'hFFFF_FFFF, 1'b1, 1'b0));
        applyStimulus("halt_branch_oor", 1'b0, 1'b1, 32'd2000, 1'b0, 32'h0, expBub(32'h5, 1'b0, 1'b1));
        stepPlain("halt_fault_hold", expBub(32'h5, 1'b0, 1'b1));

        clearInputs();
        @(negedge Clk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
